data_mover_sched: RTL and testbench
===================================

Name: data_mover_sched

Overview:
Round-robin scheduler that shares one data_mover instance between NREQ requesters. Each requester presents a move descriptor (source, destination, byte count, burst size) with a valid/ready handshake. The block arbitrates and validates the winning descriptor, then drives data_mover's start/address/count inputs and watches its idle output. On completion it returns a status record with requester ID and elapsed cycles. It sits between the control-plane requesters and the data_mover configuration inputs.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 512, data_mover data width in bits; sets minimum burst size DW/8 bytes
IDW, 3, requester-ID width; must satisfy 2**IDW >= NREQ

Ports:
clk  in  1  sole clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-requester descriptor valid
req_ready  out  NREQ  per-requester accept, one-hot, one-cycle pulse
req_src  in  NREQ*64  flattened source addresses, requester i at [64*i +: 64]
req_dst  in  NREQ*64  flattened destination addresses
req_len  in  NREQ*64  flattened byte counts
req_burst  in  NREQ*13  flattened burst sizes in bytes
dm_src_address  out  64  to data_mover src_address (registered)
dm_dst_address  out  64  to data_mover dst_address
dm_byte_count  out  64  to data_mover byte_count
dm_burst_size  out  13  to data_mover burst_size
dm_start  out  1  one-cycle start pulse to data_mover
dm_idle  in  1  data_mover idle
cmp_valid  out  1  completion record valid
cmp_ready  in  1  completion consumer ready
cmp_id  out  IDW  requester index of completed descriptor
cmp_status  out  2  0 OK, 1 bad burst, 2 bad length, 3 misaligned
cmp_cycles  out  32  cycles from dm_start to idle observed, saturating
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync-free release): state IDLE, all outputs 0, rr pointer = NREQ-1 (requester 0 has first priority).
- IDLE: if any req_valid, winner = first set bit searching from (ptr+1) mod NREQ upward with wrap. Same cycle: req_ready[winner]=1, latch winner descriptor into dm_* registers and winner index, ptr <= winner, go CHECK. Not qualified by dm_idle; data_mover is idle by construction in IDLE.
- req_ready is combinational from req_valid and ptr in IDLE only; 0 in all other states. Requester must hold descriptor stable while valid.
- CHECK (1 cycle), checks in priority order:
  - burst_size not a power of two, or < DW/8, or > 4096, or burst_size/(DW/8) > 256 -> status 1
  - byte_count == 0, or byte_count not a multiple of burst_size -> status 2
  - src or dst not aligned to burst_size -> status 3
  - Any failure -> COMPLETE, no dm_start; pass -> START.
- START: dm_start=1 for exactly one cycle, cycle counter <= 0, go RUN.
- RUN: counter increments each cycle, saturating at 0xFFFF_FFFF. First cycle with dm_idle=1 -> COMPLETE. dm_idle is low from the dm_start cycle onward, so no blanking is needed.
- COMPLETE: cmp_valid=1 with cmp_id/cmp_status/cmp_cycles held stable until cmp_valid&cmp_ready, then IDLE. cmp_cycles=0 for rejected descriptors.
- Earliest re-arbitration is the cycle after the cmp handshake, giving one descriptor in flight. Back-to-back grant latency from cmp handshake to next req_ready is 1 cycle.
- dm_* address/count/burst registers change only on grant and hold through RUN.
- Reset mid-operation returns to IDLE immediately and drops dm_start and cmp_valid. data_mover must be reset concurrently by the system; the scheduler does not recover an in-flight move.
- Requester dropping req_valid before grant is legal; it is simply not selected.

Test Plan:
- Single request, DW=512: req0 src=0x1000, dst=0x8000, len=4096, burst=1024 -> req_ready[0] pulse, dm_start 2 cycles later, cmp_status=0, cmp_id=0, cmp_cycles = measured run length.
- All four requesters valid continuously -> grant order 0,1,2,3,0 and exactly one dm_start per completion.
- req1 burst=96 -> status 1. burst=32 -> status 1. len=1000, burst=512 -> status 2. len=0 -> status 2. src=0x1040, burst=1024 -> status 3. In all cases no dm_start and cmp_cycles=0.
- Hold cmp_ready=0 for 20 cycles after completion -> cmp fields stable, req_ready stays 0, no new dm_start; release -> next grant the following cycle.
- Assert reset during RUN -> all outputs 0 asynchronously. After release, requester 0 has priority and the next move runs normally.
- dm_idle held low 0x1_0000_0005 cycles (forced) -> cmp_cycles saturates at 0xFFFFFFFF.

Source files
------------

// File: rtl/data_mover_sched.sv
// data_mover_sched: round-robin scheduler sharing one data_mover among NREQ requesters,
// validating each descriptor before launch and returning a completion record.
module data_mover_sched #(
  parameter int NREQ = 4,
  parameter int DW   = 512,
  parameter int IDW  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*64-1:0] req_src,
  input  logic [NREQ*64-1:0] req_dst,
  input  logic [NREQ*64-1:0] req_len,
  input  logic [NREQ*13-1:0] req_burst,
  output logic [63:0]       dm_src_address,
  output logic [63:0]       dm_dst_address,
  output logic [63:0]       dm_byte_count,
  output logic [12:0]       dm_burst_size,
  output logic              dm_start,
  input  logic              dm_idle,
  output logic              cmp_valid,
  input  logic              cmp_ready,
  output logic [IDW-1:0]    cmp_id,
  output logic [1:0]        cmp_status,
  output logic [31:0]       cmp_cycles,
  output logic              busy
);
  localparam logic [12:0] MIN_BURST = 13'(DW / 8);
  typedef enum logic [2:0] {IDLE, CHECK, START, RUN, COMPLETE} state_t;
  state_t state, nxt;
  logic [IDW-1:0] ptr, win;
  logic found;
  logic [1:0] chk;
  logic [63:0] mask;
  logic [31:0] cyc;
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req_valid[(int'(ptr) + k) % NREQ]) begin
        win = IDW'((int'(ptr) + k) % NREQ);
        found = 1'b1;
      end
    end
  end
  // burst is a validated power of two before the length/alignment masks are trusted
  assign mask = {51'b0, dm_burst_size - 13'd1};
  assign chk = (dm_burst_size == 13'd0 || (dm_burst_size & (dm_burst_size - 13'd1)) != 13'd0 ||
                dm_burst_size < MIN_BURST || dm_burst_size > 13'd4096 ||
                (32'(dm_burst_size) / 32'(DW / 8)) > 32'd256) ? 2'd1 :
               (dm_byte_count == 64'd0 || (dm_byte_count & mask) != 64'd0) ? 2'd2 :
               (((dm_src_address | dm_dst_address) & mask) != 64'd0) ? 2'd3 : 2'd0;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = found ? CHECK : IDLE;
      CHECK:    nxt = (chk != 2'd0) ? COMPLETE : START;
      START:    nxt = RUN;
      RUN:      nxt = dm_idle ? COMPLETE : RUN;
      COMPLETE: nxt = cmp_ready ? IDLE : COMPLETE;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= IDW'(NREQ - 1);
      dm_src_address <= '0;
      dm_dst_address <= '0;
      dm_byte_count <= '0;
      dm_burst_size <= '0;
      cmp_id <= '0;
      cmp_status <= '0;
      cyc <= '0;
    end else begin
      if (state == IDLE && found) begin
        ptr <= win;
        cmp_id <= win;
        dm_src_address <= req_src[64*win +: 64];
        dm_dst_address <= req_dst[64*win +: 64];
        dm_byte_count <= req_len[64*win +: 64];
        dm_burst_size <= req_burst[13*win +: 13];
        cyc <= '0;
      end
      if (state == CHECK) cmp_status <= chk;
      if (state == START) cyc <= '0;
      if (state == RUN && cyc != '1) cyc <= cyc + 32'd1;
    end
  end
  assign req_ready = (state == IDLE && found && !reset) ? NREQ'(1) << win : '0;
  assign dm_start = (state == START);
  assign cmp_valid = (state == COMPLETE);
  assign busy = (state != IDLE);
  assign cmp_cycles = cyc;
endmodule

// File: tb/tb_data_mover_sched.sv
// tb_data_mover_sched: table vectors, hand-written corner sequences and a randomized
// run scored against a descriptor-rule and round-robin reference model.
module tb_data_mover_sched;
  localparam int NREQ = 4, DW = 512, IDW = 3;
  typedef struct {
    logic [63:0] s, d, l;
    logic [12:0] b;
    logic [1:0]  st;
    int          id;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1;
  logic [NREQ-1:0] req_valid = '0, req_ready;
  logic [NREQ*64-1:0] req_src, req_dst, req_len;
  logic [NREQ*13-1:0] req_burst;
  logic [63:0] src_a[NREQ], dst_a[NREQ], len_a[NREQ];
  logic [12:0] burst_a[NREQ];
  logic [63:0] dm_src_address, dm_dst_address, dm_byte_count;
  logic [12:0] dm_burst_size;
  logic dm_start, dm_idle = 1'b1, cmp_valid, cmp_ready = 1'b0, busy;
  logic [IDW-1:0] cmp_id;
  logic [1:0] cmp_status;
  logic [31:0] cmp_cycles;
  int vecs = 0, errs = 0, starts = 0, fixed_len = 0, last_len = 0;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_src[64*g +: 64] = src_a[g];
    assign req_dst[64*g +: 64] = dst_a[g];
    assign req_len[64*g +: 64] = len_a[g];
    assign req_burst[13*g +: 13] = burst_a[g];
  end

  data_mover_sched #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .req_len(req_len), .req_burst(req_burst),
    .dm_src_address(dm_src_address), .dm_dst_address(dm_dst_address),
    .dm_byte_count(dm_byte_count), .dm_burst_size(dm_burst_size), .dm_start(dm_start),
    .dm_idle(dm_idle), .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_id(cmp_id),
    .cmp_status(cmp_status), .cmp_cycles(cmp_cycles), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (dm_start) starts++;

  // data_mover stand-in: goes busy on start, reports idle after last_len run cycles
  initial forever begin
    @(negedge clk);
    if (dm_start === 1'b1) begin
      dm_idle = 1'b0;
      last_len = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 6));
      for (int k = 0; k < last_len && !reset; k++) @(negedge clk);
      dm_idle = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] ref_status(input logic [63:0] s, d, l, input logic [12:0] b);
    int bi = int'(b);
    if ($countones(b) != 1 || bi < DW / 8 || bi > 4096 || bi / (DW / 8) > 256) return 2'd1;
    if (l == 64'd0 || l % 64'(bi) != 64'd0) return 2'd2;
    if (s % 64'(bi) != 64'd0 || d % 64'(bi) != 64'd0) return 2'd3;
    return 2'd0;
  endfunction

  function automatic int rr_pick(input int p, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic check_zero(input string tag);
    chk64({tag, "_ready"}, 64'(req_ready), 64'd0);
    chk64({tag, "_src"}, dm_src_address, 64'd0);
    chk64({tag, "_dst"}, dm_dst_address, 64'd0);
    chk64({tag, "_len"}, dm_byte_count, 64'd0);
    chk64({tag, "_burst"}, 64'(dm_burst_size), 64'd0);
    chk64({tag, "_start"}, 64'(dm_start), 64'd0);
    chk64({tag, "_cvalid"}, 64'(cmp_valid), 64'd0);
    chk64({tag, "_cid"}, 64'(cmp_id), 64'd0);
    chk64({tag, "_cstat"}, 64'(cmp_status), 64'd0);
    chk64({tag, "_ccyc"}, 64'(cmp_cycles), 64'd0);
    chk64({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = '0;
    cmp_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_good(input int i);
    src_a[i] = 64'h10000 * 64'(i + 1);
    dst_a[i] = 64'h80000 + 64'h1000 * 64'(i);
    len_a[i] = 64'd256;
    burst_a[i] = 13'd64;
  endtask

  task automatic gen(input int i);
    int r, e;
    logic [12:0] b;
    r = int'($urandom_range(0, 9));
    e = int'($urandom_range(6, 12));
    b = (r == 0) ? 13'($urandom) : (r == 1) ? 13'd32 : 13'(1 << e);
    burst_a[i] = b;
    len_a[i] = (r == 2) ? 64'($urandom_range(0, 5000)) : 64'(b) * 64'($urandom_range(0, 8));
    src_a[i] = 64'(b) * 64'($urandom_range(0, 999)) + ((r == 3) ? 64'($urandom_range(1, 63)) : 64'd0);
    dst_a[i] = 64'(b) * 64'($urandom_range(0, 999)) + ((r == 4) ? 64'($urandom_range(1, 63)) : 64'd0);
  endtask

  task automatic run_one(input vec_t v, input int len);
    int n, st0;
    st0 = starts;
    fixed_len = len;
    @(negedge clk);
    src_a[v.id] = v.s;
    dst_a[v.id] = v.d;
    len_a[v.id] = v.l;
    burst_a[v.id] = v.b;
    req_valid = NREQ'(1 << v.id);
    #1 chk64("grant_ready", 64'(req_ready), 64'(1 << v.id));
    @(negedge clk);
    req_valid = '0;
    #1 chk64("latched_src", dm_src_address, v.s);
    chk64("latched_dst", dm_dst_address, v.d);
    chk64("latched_len", dm_byte_count, v.l);
    chk64("latched_burst", 64'(dm_burst_size), 64'(v.b));
    @(negedge clk);
    #1 chk64("start_pulse", 64'(dm_start), 64'(v.st == 2'd0));
    n = 0;
    while (!cmp_valid && n < 100) begin
      @(negedge clk);
      #1 n++;
    end
    chk64("cmp_wait", 64'(cmp_valid), 64'd1);
    chk64("cmp_id", 64'(cmp_id), 64'(v.id));
    chk64("cmp_status", 64'(cmp_status), 64'(v.st));
    chk64("cmp_cycles", 64'(cmp_cycles), (v.st == 2'd0) ? 64'(len) : 64'd0);
    chk64("start_count", 64'(starts - st0), 64'(v.st == 2'd0));
    cmp_ready = 1'b1;
    @(negedge clk);
    cmp_ready = 1'b0;
    #1 chk64("post_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    vec_t tv[13];
    int n, st0, ng, nc, ptr_m, w, n_ok;
    int grants[8];
    logic inflight;
    logic [NREQ-1:0] drop, exp_ready;
    logic [1:0] q_st[$];
    int q_id[$];
    logic [1:0] est;
    int eid;
    tv[0]  = '{64'h1000, 64'h8000, 64'd4096, 13'd1024, 2'd0, 0};
    tv[1]  = '{64'h0, 64'h0, 64'd4096, 13'd96, 2'd1, 1};
    tv[2]  = '{64'h0, 64'h0, 64'd4096, 13'd32, 2'd1, 1};
    tv[3]  = '{64'h0, 64'h0, 64'd1000, 13'd512, 2'd2, 1};
    tv[4]  = '{64'h0, 64'h0, 64'd0, 13'd512, 2'd2, 1};
    tv[5]  = '{64'h1040, 64'h8000, 64'd4096, 13'd1024, 2'd3, 1};
    tv[6]  = '{64'h2000, 64'h2020, 64'd128, 13'd64, 2'd3, 2};
    tv[7]  = '{64'h10000, 64'h20000, 64'd8192, 13'd4096, 2'd0, 3};
    tv[8]  = '{64'h0, 64'h0, 64'd8192, 13'd8192, 2'd1, 2};
    tv[9]  = '{64'h40, 64'h80, 64'd64, 13'd64, 2'd0, 1};
    tv[10] = '{64'h0, 64'h0, 64'd64, 13'd0, 2'd1, 0};
    tv[11] = '{64'h0, 64'h0, 64'd4160, 13'd4096, 2'd2, 3};
    tv[12] = '{64'h10, 64'h0, 64'd1000, 13'd512, 2'd2, 2};
    for (int i = 0; i < NREQ; i++) set_good(i);

    // reset holds every output low even with all requesters asking
    req_valid = '1;
    repeat (3) @(negedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    req_valid = '0;
    reset = 1'b0;

    for (int i = 0; i < 13; i++) run_one(tv[i], 1 + i % 5);

    // completion back-pressure
    fixed_len = 4;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) set_good(i);
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '1;
    n = 0;
    while (!cmp_valid && n < 100) begin
      @(negedge clk);
      #1 n++;
    end
    st0 = starts;
    fixed_len = 30;
    for (int c = 0; c < 20; c++) begin
      chk64("hold_ready", 64'(req_ready), 64'd0);
      chk64("hold_valid", 64'(cmp_valid), 64'd1);
      chk64("hold_id", 64'(cmp_id), 64'd2);
      chk64("hold_status", 64'(cmp_status), 64'd0);
      chk64("hold_cycles", 64'(cmp_cycles), 64'd4);
      @(negedge clk);
      #1;
    end
    chk64("hold_starts", 64'(starts - st0), 64'd0);
    cmp_ready = 1'b1;
    @(negedge clk);
    cmp_ready = 1'b0;
    #1 chk64("regrant_latency", 64'(req_ready), 64'b1000);

    // reset while requester 3 is running
    repeat (3) @(negedge clk);
    #1 chk64("in_run_busy", 64'(busy), 64'd1);
    #1 reset = 1'b1;
    #1 check_zero("midrun");
    @(negedge clk);
    reset = 1'b0;
    #1 chk64("post_reset_prio", 64'(req_ready), 64'b0001);

    // all requesters valid continuously
    cmp_ready = 1'b1;
    fixed_len = 2;
    st0 = starts;
    ng = 0;
    nc = 0;
    n = 0;
    while (nc < 5 && n < 300) begin
      if (req_ready != '0 && ng < 8) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) grants[ng] = i;
        ng++;
      end
      if (cmp_valid) nc++;
      @(negedge clk);
      #1 n++;
    end
    chk64("rr_completions", 64'(nc), 64'd5);
    chk64("rr_grants", 64'(ng), 64'd5);
    for (int i = 0; i < 5; i++) chk64("rr_order", 64'(grants[i]), 64'(i % NREQ));
    chk64("rr_starts", 64'(starts - st0), 64'd5);

    // saturating cycle counter
    do_reset();
    fixed_len = 12;
    @(negedge clk);
    set_good(0);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    force dut.cyc = 32'hFFFF_FFFA;
    @(negedge clk);
    release dut.cyc;
    n = 0;
    while (!cmp_valid && n < 100) begin
      @(negedge clk);
      #1 n++;
    end
    chk64("sat_valid", 64'(cmp_valid), 64'd1);
    chk64("sat_cycles", 64'(cmp_cycles), 64'hFFFF_FFFF);
    cmp_ready = 1'b1;
    @(negedge clk);
    cmp_ready = 1'b0;

    // randomized traffic against the reference model
    do_reset();
    fixed_len = 0;
    ptr_m = NREQ - 1;
    inflight = 1'b0;
    drop = '0;
    n_ok = 0;
    st0 = starts;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (drop[i]) begin
          req_valid[i] = 1'b0;
          drop[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          gen(i);
          req_valid[i] = 1'b1;
        end
      end
      cmp_ready = ($urandom_range(0, 2) != 0);
      #1 chk64("rnd_busy", 64'(busy), 64'(inflight));
      w = (!inflight) ? rr_pick(ptr_m, req_valid) : -1;
      exp_ready = (w >= 0) ? NREQ'(1 << w) : '0;
      chk64("rnd_ready", 64'(req_ready), 64'(exp_ready));
      if (w >= 0) begin
        ptr_m = w;
        inflight = 1'b1;
        drop[w] = 1'b1;
        q_id.push_back(w);
        q_st.push_back(ref_status(src_a[w], dst_a[w], len_a[w], burst_a[w]));
      end else if (cmp_valid && cmp_ready) begin
        if (q_id.size() == 0) begin
          chk64("rnd_unexpected_cmp", 64'(cmp_valid), 64'd0);
        end else begin
          eid = q_id.pop_front();
          est = q_st.pop_front();
          if (est == 2'd0) n_ok++;
          chk64("rnd_id", 64'(cmp_id), 64'(eid));
          chk64("rnd_status", 64'(cmp_status), 64'(est));
          chk64("rnd_cycles", 64'(cmp_cycles), (est == 2'd0) ? 64'(last_len) : 64'd0);
          chk64("rnd_starts", 64'(starts - st0), 64'(n_ok));
        end
        inflight = 1'b0;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
